// File: rtl/adc_spi_pkg.sv
// Shared constants for the serial ADC reader: timing defaults and FSM encoding.
package adc_spi_pkg;

  localparam int unsigned DEF_NB_ADC     = 12;
  localparam int unsigned DEF_NB_FRAME   = 16;
  localparam int unsigned DEF_LEAD_ZEROS = 4;
  localparam int unsigned DEF_CLK_DIV    = 2;
  localparam int unsigned DEF_T_QUIET    = 3;

  // System-clock cycles spent in SHIFT for the default timing.
  localparam int unsigned FRAME_CYCLES = 2 * DEF_CLK_DIV * DEF_NB_FRAME;

  localparam int unsigned ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam logic [ST_W-1:0] IDLE     = 3'd0;
  localparam logic [ST_W-1:0] CS_SETUP = 3'd1;
  localparam logic [ST_W-1:0] SHIFT    = 3'd2;
  localparam logic [ST_W-1:0] CS_HOLD  = 3'd3;
  localparam logic [ST_W-1:0] QUIET    = 3'd4;

  // Counter width for a count range of 'bound' values, never below one bit.
  function automatic int unsigned cnt_w(input int unsigned bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/adc_spi_reader_if.sv
// Scan-controller handshake plus the SPI pins of the serial ADC reader.
interface adc_spi_reader_if #(
  parameter int unsigned NB_ADC = adc_spi_pkg::DEF_NB_ADC
);

  logic              i_adc_trig;
  logic              o_adc_done;
  logic [NB_ADC-1:0] o_adc_data;
  logic              o_busy;
  logic              o_overrun;
  logic              o_spi_cs_n;
  logic              o_spi_sclk;
  logic              i_spi_miso;

  // Reader side.
  modport slave (
    input  i_adc_trig, i_spi_miso,
    output o_adc_done, o_adc_data, o_busy, o_overrun, o_spi_cs_n, o_spi_sclk
  );

  // Scan controller / ADC side.
  modport master (
    output i_adc_trig, i_spi_miso,
    input  o_adc_done, o_adc_data, o_busy, o_overrun, o_spi_cs_n, o_spi_sclk
  );

endinterface

// File: rtl/adc_spi_reader_sclk_gen.sv
// SCLK generator: half-period divider, registered sclk, rise and end-of-high strobes.
// While run is high it alternates high/low phases of CLK_DIV cycles, starting with
// a high phase; the CS setup time is that first high phase.
module spi_sclk_gen
  import adc_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic last_bit,
  output logic sclk,
  output logic rise_c,
  output logic bit_done_c
);

  localparam int unsigned      CNT_W    = cnt_w(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             phase_end_c;

  // Strobes for the edge that ends the current phase.
  always_comb begin
    phase_end_c = (div_cnt == CNT_LAST);
    rise_c      = run && !sclk && phase_end_c;
    bit_done_c  = run && sclk && phase_end_c;
  end

  // Divider and sclk register; sclk parks high when idle and after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b1;
    end else if (!run) begin
      div_cnt <= '0;
      sclk    <= 1'b1;
    end else if (phase_end_c) begin
      div_cnt <= '0;
      if (!(sclk && last_bit)) sclk <= ~sclk;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// Serial ADC front-end: runs one SPI read frame per trigger and presents the sample.
module adc_spi_reader
  import adc_spi_pkg::*;
#(
  parameter int unsigned NB_ADC     = DEF_NB_ADC,
  parameter int unsigned NB_FRAME   = DEF_NB_FRAME,
  parameter int unsigned LEAD_ZEROS = DEF_LEAD_ZEROS,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned T_QUIET    = DEF_T_QUIET
) (
  input logic            clk,
  input logic            i_rst,
  adc_spi_reader_if.slave bus
);

  localparam int unsigned      BIT_W    = cnt_w(NB_FRAME);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB_FRAME - 1);
  localparam int unsigned      Q_W      = cnt_w(T_QUIET);
  localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(T_QUIET - 1);
  // Leading frame bits fall off the top of the shift register.
  localparam int unsigned      SR_W     = NB_FRAME - LEAD_ZEROS;

  state_t            state;
  state_t            state_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [Q_W-1:0]    q_cnt;
  logic [SR_W-1:0]   shift_reg;
  logic              last_bit_c;
  logic              sclk_run_c;
  logic              sclk;
  logic              rise_c;
  logic              bit_done_c;

  logic              cs_n;
  logic              done;
  logic [NB_ADC-1:0] adc_data;
  logic              busy;
  logic              overrun;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (i_rst),
    .run        (sclk_run_c),
    .last_bit   (last_bit_c),
    .sclk       (sclk),
    .rise_c     (rise_c),
    .bit_done_c (bit_done_c)
  );

  // State register.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and sclk generator control.
  always_comb begin
    state_nxt  = state;
    last_bit_c = (state == SHIFT) && (bit_cnt == BIT_LAST);
    sclk_run_c = (state == CS_SETUP) || (state == SHIFT);
    case (state)
      IDLE:     if (bus.i_adc_trig) state_nxt = CS_SETUP;
      CS_SETUP: if (bit_done_c) state_nxt = SHIFT;
      SHIFT:    if (bit_done_c && last_bit_c) state_nxt = CS_HOLD;
      CS_HOLD:  state_nxt = QUIET;
      QUIET:    if (q_cnt == Q_LAST) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Frame bit counter and quiet-time counter; both saturate at their terminal count.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      bit_cnt <= '0;
      q_cnt   <= '0;
    end else begin
      if (state != SHIFT)                  bit_cnt <= '0;
      else if (bit_done_c && !last_bit_c)  bit_cnt <= bit_cnt + BIT_W'(1);
      if (state != QUIET)                  q_cnt <= '0;
      else if (q_cnt != Q_LAST)            q_cnt <= q_cnt + Q_W'(1);
    end
  end

  // MISO shift register, sampled only on the sclk rising edge.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst)                         shift_reg <= '0;
    else if (state == IDLE)             shift_reg <= '0;
    else if (rise_c && state == SHIFT)  shift_reg <= {shift_reg[SR_W-2:0], bus.i_spi_miso};
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      cs_n     <= 1'b1;
      done     <= 1'b0;
      adc_data <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      cs_n <= !((state_nxt == CS_SETUP) || (state_nxt == SHIFT));
      done <= (state_nxt == CS_HOLD);
      busy <= (state_nxt != IDLE);
      if (state == SHIFT && state_nxt == CS_HOLD)
        adc_data <= shift_reg[SR_W-1 -: NB_ADC];
      if (bus.i_adc_trig && state != IDLE)
        overrun <= 1'b1;
    end
  end

  assign bus.o_spi_cs_n = cs_n;
  assign bus.o_spi_sclk = sclk;
  assign bus.o_adc_done = done;
  assign bus.o_adc_data = adc_data;
  assign bus.o_busy     = busy;
  assign bus.o_overrun  = overrun;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Self-checking bench for adc_spi_reader: default instance plus a CLK_DIV=1/T_QUIET=1 instance.
`timescale 1ns/1ps
module tb_adc_spi_reader;
  import adc_spi_pkg::*;

  localparam int CD1 = 1;
  localparam int TQ1 = 1;

  typedef struct {
    logic [11:0] data;
    int          at;
  } exp_t;

  typedef struct {
    logic [15:0] frame;
    int          hold;
    int          xa;
    int          xb;
    logic [11:0] exp_data;
    logic        exp_ovr;
    int          exp_ovr_rel;
  } vec_t;

  logic clk;
  logic i_rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  adc_spi_reader_if #(.NB_ADC(12)) bus0 ();
  adc_spi_reader_if #(.NB_ADC(12)) bus1 ();

  adc_spi_reader u_dut0 (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus0.slave)
  );

  adc_spi_reader #(
    .CLK_DIV (CD1),
    .T_QUIET (TQ1)
  ) u_dut1 (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus1.slave)
  );

  logic [1:0]  trig_v = '0;
  logic [1:0]  miso_v = '0;
  logic [15:0] frame_v [2];

  assign bus0.i_adc_trig = trig_v[0];
  assign bus1.i_adc_trig = trig_v[1];
  assign bus0.i_spi_miso = miso_v[0];
  assign bus1.i_spi_miso = miso_v[1];

  logic [1:0]  cs_t, sclk_t, done_t, busy_t, ovr_t;
  logic [11:0] data_t [2];
  assign cs_t      = {bus1.o_spi_cs_n, bus0.o_spi_cs_n};
  assign sclk_t    = {bus1.o_spi_sclk, bus0.o_spi_sclk};
  assign done_t    = {bus1.o_adc_done, bus0.o_adc_done};
  assign busy_t    = {bus1.o_busy, bus0.o_busy};
  assign ovr_t     = {bus1.o_overrun, bus0.o_overrun};
  assign data_t[0] = bus0.o_adc_data;
  assign data_t[1] = bus1.o_adc_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int div_of(input int d);
    return (d == 0) ? int'(DEF_CLK_DIV) : CD1;
  endfunction

  function automatic int done_rel(input int d);
    return (d == 0) ? int'(DEF_CLK_DIV + FRAME_CYCLES + 1) : (CD1 + 2 * CD1 * 16 + 1);
  endfunction

  function automatic int busy_rel(input int d);
    return done_rel(d) + ((d == 0) ? int'(DEF_T_QUIET) : TQ1) + 1;
  endfunction

  // Monitor records and the ADC serial model.
  int          cs_fall [2], cs_rise [2], busy_fall [2], ovr_set [2];
  int          rise_cnt [2], last_rise [2], bad_int [2], idle_bad [2];
  int          done_cnt [2] = '{0, 0};
  logic [11:0] log_data [2][64];
  int          log_cyc  [2][64];
  int          bit_idx  [2];
  logic [1:0]  cur_bit = '0;
  logic [1:0]  prev_sclk = '1, prev_cs = '1, prev_busy = '0, prev_ovr = '0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!i_rst) begin
        cs_fall[d] = -1; cs_rise[d] = -1; busy_fall[d] = -1; ovr_set[d] = -1;
        rise_cnt[d] = 0; last_rise[d] = -1; bad_int[d] = 0; idle_bad[d] = 0;
      end else begin
        if (prev_cs[d] && !cs_t[d]) cs_fall[d] = cyc;
        if (!prev_cs[d] && cs_t[d]) cs_rise[d] = cyc;
        if (prev_busy[d] && !busy_t[d]) busy_fall[d] = cyc;
        if (!prev_ovr[d] && ovr_t[d] && ovr_set[d] < 0) ovr_set[d] = cyc;
        if (cs_t[d] && !sclk_t[d]) idle_bad[d]++;
        if (cs_t[d]) last_rise[d] = -1;
        else if (sclk_t[d] && !prev_sclk[d]) begin
          rise_cnt[d]++;
          if (last_rise[d] >= 0 && (cyc - last_rise[d]) != 2 * div_of(d)) bad_int[d]++;
          last_rise[d] = cyc;
        end
        if (done_t[d] && done_cnt[d] < 64) begin
          log_data[d][6'(done_cnt[d])] = data_t[d];
          log_cyc[d][6'(done_cnt[d])]  = cyc;
          done_cnt[d]++;
        end
      end
      // ADC drives a new bit after each sclk fall; data is garbage while sclk is high.
      if (cs_t[d]) begin
        bit_idx[d] = 0;
        miso_v[d]  = 1'b0;
      end else if (prev_sclk[d] && !sclk_t[d]) begin
        cur_bit[d] = (bit_idx[d] < 16) ? frame_v[d][4'(15 - bit_idx[d])] : 1'b0;
        miso_v[d]  = cur_bit[d];
        bit_idx[d]++;
      end else if (sclk_t[d]) begin
        miso_v[d] = ~cur_bit[d];
      end
      prev_sclk[d] = sclk_t[d];
      prev_cs[d]   = cs_t[d];
      prev_busy[d] = busy_t[d];
      prev_ovr[d]  = ovr_t[d];
    end
  end

  exp_t sb0[$];
  exp_t sb1[$];
  int   rd_ptr [2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Pop one expected result for every done pulse the monitor has logged.
  task automatic drain();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      while (rd_ptr[d] < done_cnt[d]) begin
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL dut%0d_unexpected_done: got done at cycle %0d, expected none",
                   d, log_cyc[d][6'(rd_ptr[d])]);
        end else begin
          if (d == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          chk($sformatf("dut%0d_done_data", d), 32'(log_data[d][6'(rd_ptr[d])]), 32'(e.data));
          chk($sformatf("dut%0d_done_cycle", d), log_cyc[d][6'(rd_ptr[d])], e.at);
        end
        rd_ptr[d]++;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      drain();
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    step(2);
    i_rst = 1'b1;
    step(2);
  endtask

  // One complete frame on the default instance driven from a table entry.
  task automatic run_vec(input vec_t v, input int idx);
    int t0;
    do_reset();
    frame_v[0] = v.frame;
    t0 = cyc;
    sb0.push_back('{data: v.exp_data, at: t0 + done_rel(0)});
    trig_v[0] = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      step(1);
      trig_v[0] = (k < v.hold) || (k == v.xa) || (k == v.xb);
    end
    chk($sformatf("v%0d_cs_fall", idx), cs_fall[0] - t0, 1);
    chk($sformatf("v%0d_cs_rise", idx), cs_rise[0] - t0, done_rel(0));
    chk($sformatf("v%0d_busy_fall", idx), busy_fall[0] - t0, busy_rel(0));
    chk($sformatf("v%0d_sclk_rises", idx), rise_cnt[0], 16);
    chk($sformatf("v%0d_sclk_period_bad", idx), bad_int[0], 0);
    chk($sformatf("v%0d_sclk_idle_bad", idx), idle_bad[0], 0);
    chk($sformatf("v%0d_overrun", idx), 32'(ovr_t[0]), 32'(v.exp_ovr));
    if (v.exp_ovr_rel > 0)
      chk($sformatf("v%0d_overrun_cycle", idx), ovr_set[0] - t0, v.exp_ovr_rel);
    chk($sformatf("v%0d_sb_left", idx), sb0.size(), 0);
  endtask

  vec_t vecs [6];

  initial begin
    int t0;
    int t1;
    int dcnt;
    frame_v[0] = '0;
    frame_v[1] = '0;

    vecs[0] = '{frame: 16'h0ABC, hold: 1, xa: 0,  xb: 0,  exp_data: 12'hABC, exp_ovr: 1'b0, exp_ovr_rel: 0};
    vecs[1] = '{frame: 16'hF5A3, hold: 1, xa: 0,  xb: 0,  exp_data: 12'h5A3, exp_ovr: 1'b0, exp_ovr_rel: 0};
    vecs[2] = '{frame: 16'h0C3C, hold: 1, xa: 10, xb: 69, exp_data: 12'hC3C, exp_ovr: 1'b1, exp_ovr_rel: 11};
    vecs[3] = '{frame: 16'h0801, hold: 5, xa: 0,  xb: 0,  exp_data: 12'h801, exp_ovr: 1'b1, exp_ovr_rel: 2};
    vecs[4] = '{frame: 16'h0000, hold: 1, xa: 0,  xb: 0,  exp_data: 12'h000, exp_ovr: 1'b0, exp_ovr_rel: 0};
    vecs[5] = '{frame: 16'hFFFF, hold: 1, xa: 0,  xb: 0,  exp_data: 12'hFFF, exp_ovr: 1'b0, exp_ovr_rel: 0};

    // Values held while reset is asserted.
    step(2);
    chk("rst_cs_n", 32'(cs_t[0]), 1);
    chk("rst_sclk", 32'(sclk_t[0]), 1);
    chk("rst_done", 32'(done_t[0]), 0);
    chk("rst_data", 32'(data_t[0]), 0);
    chk("rst_busy", 32'(busy_t[0]), 0);
    chk("rst_overrun", 32'(ovr_t[0]), 0);
    chk("rst_dut1_cs_n", 32'(cs_t[1]), 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Back-to-back frames: next trigger on the first IDLE cycle.
    do_reset();
    frame_v[0] = 16'hFFFF;
    t0 = cyc;
    sb0.push_back('{data: 12'hFFF, at: t0 + done_rel(0)});
    trig_v[0] = 1'b1;
    step(1);
    trig_v[0] = 1'b0;
    step(69);
    chk("b2b_busy_last_quiet", 32'(busy_t[0]), 1);
    step(1);
    chk("b2b_busy_idle", 32'(busy_t[0]), 0);
    frame_v[0] = 16'h0000;
    t1 = cyc;
    sb0.push_back('{data: 12'h000, at: t1 + done_rel(0)});
    trig_v[0] = 1'b1;
    step(1);
    trig_v[0] = 1'b0;
    chk("b2b_second_cs_low", 32'(cs_t[0]), 0);
    chk("b2b_second_start", t1 - t0, busy_rel(0));
    step(80);
    chk("b2b_overrun", 32'(ovr_t[0]), 0);
    chk("b2b_sb_left", sb0.size(), 0);

    // Reset asserted mid-SHIFT aborts immediately; a fresh frame then completes.
    do_reset();
    frame_v[0] = 16'h0FFF;
    t0 = cyc;
    sb0.push_back('{data: 12'hFFF, at: t0 + done_rel(0)});
    trig_v[0] = 1'b1;
    step(1);
    trig_v[0] = 1'b0;
    step(80);
    frame_v[0] = 16'h05A5;
    trig_v[0] = 1'b1;
    step(1);
    trig_v[0] = 1'b0;
    step(29);
    chk("abort_pre_cs_n", 32'(cs_t[0]), 0);
    dcnt = done_cnt[0];
    i_rst = 1'b0;
    #1;
    chk("abort_cs_n", 32'(cs_t[0]), 1);
    chk("abort_sclk", 32'(sclk_t[0]), 1);
    chk("abort_data", 32'(data_t[0]), 0);
    chk("abort_busy", 32'(busy_t[0]), 0);
    step(3);
    i_rst = 1'b1;
    step(10);
    chk("abort_waits_trigger", 32'(cs_t[0]), 1);
    chk("abort_no_done", done_cnt[0] - dcnt, 0);
    t0 = cyc;
    sb0.push_back('{data: 12'h5A5, at: t0 + done_rel(0)});
    trig_v[0] = 1'b1;
    step(1);
    trig_v[0] = 1'b0;
    step(80);
    chk("abort_new_cs_fall", cs_fall[0] - t0, 1);
    chk("abort_new_cs_rise", cs_rise[0] - t0, done_rel(0));
    chk("abort_sb_left", sb0.size(), 0);

    // CLK_DIV=1, T_QUIET=1 instance.
    do_reset();
    frame_v[1] = 16'h0123;
    t0 = cyc;
    sb1.push_back('{data: 12'h123, at: t0 + done_rel(1)});
    trig_v[1] = 1'b1;
    step(1);
    trig_v[1] = 1'b0;
    step(45);
    chk("fast_cs_fall", cs_fall[1] - t0, 1);
    chk("fast_cs_rise", cs_rise[1] - t0, 34);
    chk("fast_busy_fall", busy_fall[1] - t0, busy_rel(1));
    chk("fast_sclk_rises", rise_cnt[1], 16);
    chk("fast_sclk_period_bad", bad_int[1], 0);
    chk("fast_sclk_idle_bad", idle_bad[1], 0);
    chk("fast_sb_left", sb1.size(), 0);

    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
